stepper_move_ctrl: RTL



---
 rtl/stepper_move_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/stepper_move_ctrl.sv
// rtl/stepper_move_ctrl.sv - move-command scheduler for a 4-phase unipolar stepper
//
// Accepts {dir, steps, period} over a valid/ready handshake, then steps a one-hot
// coil pattern forward or reverse every eff_period clocks and tracks position.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only in IDLE)
//   cmd_dir                  1 = forward (phase +1), 0 = reverse (phase -1)
//   cmd_steps, cmd_period    step count and clk cycles per step (clamped to MIN_PERIOD)
//   abort                    ends the current move; ignored outside RUN
//   coil                     registered one-hot coil drive, coil[0..3] = a,b,c,d
//   busy, done, done_aborted move status; done is a one-cycle pulse
//   position, steps_left     signed absolute step count, remaining steps
module stepper_move_ctrl #(
    parameter int STEP_W     = 16,
    parameter int PERIOD_W   = 16,
    parameter int POS_W      = 24,
    parameter int MIN_PERIOD = 5,
    parameter int HOLD_IDLE  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [STEP_W-1:0]   cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic [3:0]          coil,
    output logic                busy,
    output logic                done,
    output logic                done_aborted,
    output logic [POS_W-1:0]    position,
    output logic [STEP_W-1:0]   steps_left
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
    localparam logic [3:0]          COIL_RESET = (HOLD_IDLE != 0) ? 4'b0001 : 4'b0000;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_phase;
    logic [1:0]          w_phase_nx;
    logic                r_dir;
    logic [PERIOD_W-1:0] r_eff;
    logic [PERIOD_W-1:0] r_timer;
    logic [STEP_W-1:0]   r_left;
    logic [POS_W-1:0]    r_pos;
    logic [3:0]          r_coil;
    logic                r_aborted;
    logic                w_accept;
    logic                w_step;

    // Abort wins over a step falling due on the same edge.
    assign w_step   = (r_state == S_RUN) && !abort && (r_timer == r_eff - PERIOD_W'(1));
    assign w_accept = cmd_valid && (r_state == S_IDLE);

    assign w_phase_nx = !w_step ? r_phase :
                        (r_dir ? r_phase + 2'd1 : r_phase - 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (w_accept) begin
                    w_next = (cmd_steps == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    w_next = S_FINISH;
                end else if (w_step && (r_left == STEP_W'(1))) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase   <= 2'd0;
            r_dir     <= 1'b0;
            r_eff     <= MIN_P;
            r_timer   <= '0;
            r_left    <= '0;
            r_pos     <= '0;
            r_coil    <= COIL_RESET;
            r_aborted <= 1'b0;
        end else begin
            r_phase <= w_phase_nx;
            // Coil follows the next phase so it changes on the stepping edge itself.
            r_coil  <= ((w_next == S_IDLE) && (HOLD_IDLE == 0)) ? 4'b0000
                                                                 : (4'b0001 << w_phase_nx);
            if (w_accept) begin
                r_dir     <= cmd_dir;
                r_left    <= cmd_steps;
                r_eff     <= (cmd_period < MIN_P) ? MIN_P : cmd_period;
                r_timer   <= '0;
                r_aborted <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (abort) begin
                    r_aborted <= 1'b1;
                end else if (w_step) begin
                    r_timer <= '0;
                    r_left  <= r_left - STEP_W'(1);
                    r_pos   <= r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
                end else begin
                    r_timer <= r_timer + PERIOD_W'(1);
                end
            end
        end
    end

    assign coil         = r_coil;
    assign done_aborted = r_aborted;
    assign position     = r_pos;
    assign steps_left   = r_left;

endmodule
